// File: rtl/cmt_clkgen_prog.sv
// Runtime M/D reprogramming controller for up to four DCM_CLKGEN channels.
// Optional lock-loss recovery: define CMT_LOCK_MONITOR_EN.
module cmt_clkgen_prog #(
  parameter int NUM_CH     = 2,
  parameter int TIMEOUT    = 4096,
  parameter int RST_CYCLES = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [1:0]        i_cmd_ch,
  input  logic [7:0]        i_cmd_m,
  input  logic [7:0]        i_cmd_d,
  output logic [NUM_CH-1:0] o_progen,
  output logic              o_progdata,
  input  logic [NUM_CH-1:0] i_progdone,
  input  logic [NUM_CH-1:0] i_locked,
  output logic [NUM_CH-1:0] o_dcm_rst,
  output logic              o_busy,
  output logic [1:0]        o_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [2:0]    LP_NCH   = 3'(NUM_CH);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_D, S_GAP1, S_LOAD_M, S_GAP2, S_GO, S_WAIT_DONE, S_WAIT_LOCK, S_RST
  } state_t;

  state_t            r_state, w_state;
  logic [1:0]        r_ch, w_ch;
  logic [7:0]        r_m, w_m, r_d, w_d;
  logic [3:0]        r_bit, w_bit, w_bit_inc;
  logic [TW-1:0]     r_tmo, w_tmo;
  logic [RW-1:0]     r_rcnt, w_rcnt;
  logic [NUM_CH-1:0] r_progen, w_progen, r_dcm_rst, w_dcm_rst;
  logic              r_progdata, w_progdata, r_busy, w_busy, r_ready, w_ready;
  logic [1:0]        r_err, w_err;
  logic [NUM_CH-1:0] r_done_s1, r_done_s2, r_lk_s1, r_lk_s2;
  logic [9:0]        w_seq_d, w_seq_m;
  logic              w_done_ch, w_lock_ch, w_illegal;
`ifdef CMT_LOCK_MONITOR_EN
  logic [NUM_CH-1:0] r_lk_q, r_pend, w_pend, w_lost, w_mask;
  logic [1:0]        w_lost_ch;
`endif

  function automatic logic [NUM_CH-1:0] f_oh(input logic [1:0] ch);
    f_oh = '0;
    for (int i = 0; i < NUM_CH; i++) f_oh[i] = (ch == 2'(i));
  endfunction

  // Serial frames go out LSB first: two header bits, then the 8-bit value.
  assign w_seq_d   = {r_d, 2'b01};
  assign w_seq_m   = {r_m, 2'b11};
  assign w_bit_inc = r_bit + 4'd1;
  assign w_done_ch = |(r_done_s2 & f_oh(r_ch));
  assign w_lock_ch = |(r_lk_s2 & f_oh(r_ch));
  assign w_illegal = ({1'b0, i_cmd_ch} >= LP_NCH) || (i_cmd_m == 8'd0);

`ifdef CMT_LOCK_MONITOR_EN
  // The channel under programming or reset is expected to lose lock; ignore it.
  assign w_mask = (r_state == S_IDLE) ? '1 : ~f_oh(r_ch);
  assign w_lost = r_pend | (r_lk_q & ~r_lk_s2 & w_mask);
  always_comb begin
    w_lost_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (w_lost[i]) w_lost_ch = 2'(i);
  end
`endif

  always_comb begin
    w_state = r_state; w_ch = r_ch; w_m = r_m; w_d = r_d; w_bit = r_bit;
    w_tmo = r_tmo; w_rcnt = r_rcnt; w_progen = r_progen; w_progdata = r_progdata;
    w_dcm_rst = r_dcm_rst; w_busy = r_busy; w_ready = r_ready; w_err = r_err;
`ifdef CMT_LOCK_MONITOR_EN
    w_pend = w_lost;
`endif
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        w_busy  = 1'b0;
        if (i_cmd_valid && r_ready) begin
          if (w_illegal) w_err[1] = 1'b1;
          else begin
            w_state = S_LOAD_D; w_ch = i_cmd_ch; w_m = i_cmd_m; w_d = i_cmd_d;
            w_bit = '0; w_progen = f_oh(i_cmd_ch); w_progdata = 1'b1;
            w_busy = 1'b1; w_ready = 1'b0; w_err = 2'b00;
`ifdef CMT_LOCK_MONITOR_EN
            w_pend = w_lost & ~f_oh(i_cmd_ch);
`endif
          end
        end
`ifdef CMT_LOCK_MONITOR_EN
        else if (|w_lost) begin
          w_state = S_RST; w_ch = w_lost_ch; w_rcnt = '0;
          w_dcm_rst = f_oh(w_lost_ch); w_busy = 1'b1; w_ready = 1'b0;
          w_pend = w_lost & ~f_oh(w_lost_ch);
        end
`endif
      end
      S_LOAD_D, S_LOAD_M: begin
        if (r_bit == 4'd9) begin
          w_state = (r_state == S_LOAD_D) ? S_GAP1 : S_GAP2;
          w_progen = '0; w_progdata = 1'b0;
        end else begin
          w_bit = w_bit_inc;
          w_progdata = (r_state == S_LOAD_D) ? w_seq_d[w_bit_inc] : w_seq_m[w_bit_inc];
        end
      end
      S_GAP1: begin
        w_state = S_LOAD_M; w_bit = '0; w_progen = f_oh(r_ch); w_progdata = 1'b1;
      end
      S_GAP2: begin
        w_state = S_GO; w_progen = f_oh(r_ch); w_progdata = 1'b0;
      end
      S_GO: begin
        w_state = S_WAIT_DONE; w_progen = '0;
      end
      S_WAIT_DONE, S_WAIT_LOCK: begin
        // Condition is checked before the counter so it wins a same-cycle tie.
        if ((r_state == S_WAIT_DONE) ? w_done_ch : w_lock_ch) begin
          if (r_state == S_WAIT_DONE) w_state = S_WAIT_LOCK;
          else begin
            w_state = S_IDLE; w_busy = 1'b0; w_ready = 1'b1;
          end
        end else if (r_tmo == TMO_LAST) begin
          w_state = S_RST; w_err[0] = 1'b1; w_rcnt = '0; w_dcm_rst = f_oh(r_ch);
        end else w_tmo = r_tmo + 1'b1;
      end
      S_RST: begin
        if (r_rcnt == RST_LAST) begin
          w_state = S_IDLE; w_dcm_rst = '0; w_busy = 1'b0; w_ready = 1'b1;
        end else w_rcnt = r_rcnt + 1'b1;
      end
      default: w_state = S_IDLE;
    endcase
    if (w_state != r_state) w_tmo = '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE; r_ch <= '0; r_m <= '0; r_d <= '0; r_bit <= '0;
      r_tmo <= '0; r_rcnt <= '0; r_progen <= '0; r_progdata <= 1'b0;
      r_dcm_rst <= '0; r_busy <= 1'b0; r_ready <= 1'b0; r_err <= 2'b00;
      r_done_s1 <= '0; r_done_s2 <= '0; r_lk_s1 <= '0; r_lk_s2 <= '0;
`ifdef CMT_LOCK_MONITOR_EN
      r_lk_q <= '0; r_pend <= '0;
`endif
    end else begin
      r_state <= w_state; r_ch <= w_ch; r_m <= w_m; r_d <= w_d; r_bit <= w_bit;
      r_tmo <= w_tmo; r_rcnt <= w_rcnt; r_progen <= w_progen; r_progdata <= w_progdata;
      r_dcm_rst <= w_dcm_rst; r_busy <= w_busy; r_ready <= w_ready; r_err <= w_err;
      r_done_s1 <= i_progdone; r_done_s2 <= r_done_s1;
      r_lk_s1 <= i_locked; r_lk_s2 <= r_lk_s1;
`ifdef CMT_LOCK_MONITOR_EN
      r_lk_q <= r_lk_s2; r_pend <= w_pend;
`endif
    end
  end

  assign o_cmd_ready = r_ready;
  assign o_progen    = r_progen;
  assign o_progdata  = r_progdata;
  assign o_dcm_rst   = r_dcm_rst;
  assign o_busy      = r_busy;
  assign o_err       = r_err;
endmodule

// File: tb/tb_cmt_clkgen_prog.sv
// Directed bench for cmt_clkgen_prog: serial frames, illegal requests, timeout, mid-sequence reset.
module tb_cmt_clkgen_prog;
  localparam int NCH = 2;
  localparam int TMO = 32;
  localparam int RSTC = 8;

  logic clk = 1'b0;
  logic rst_n, cmd_valid, cmd_ready, progdata, busy;
  logic [1:0] cmd_ch, err;
  logic [7:0] cmd_m, cmd_d;
  logic [NCH-1:0] progen, progdone, locked, dcm_rst;
  logic [NCH:0] sb_q[$];
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cmt_clkgen_prog #(.NUM_CH(NCH), .TIMEOUT(TMO), .RST_CYCLES(RSTC)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_ch(cmd_ch), .i_cmd_m(cmd_m), .i_cmd_d(cmd_d), .o_progen(progen),
    .o_progdata(progdata), .i_progdone(progdone), .i_locked(locked),
    .o_dcm_rst(dcm_rst), .o_busy(busy), .o_err(err)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one legal request, queues the 23-cycle PROGEN/PROGDATA pattern,
  // then compares the first n cycles; the inputs are scrambled after acceptance.
  task automatic prog(input logic [1:0] ch, input logic [7:0] m, input logic [7:0] d,
                      input int n);
    logic [NCH-1:0] oh;
    logic [NCH:0] e;
    logic en, dat;
    oh = '0;
    oh[ch] = 1'b1;
    cmd_valid = 1'b1; cmd_ch = ch; cmd_m = m; cmd_d = d;
    for (int k = 0; k < 23; k++) begin
      en = !(k == 10 || k == 21);
      if (k == 0) dat = 1'b1;
      else if (k == 1) dat = 1'b0;
      else if (k < 10) dat = d[k-2];
      else if (k == 11 || k == 12) dat = 1'b1;
      else if (k > 12 && k < 21) dat = m[k-13];
      else dat = 1'b0;
      sb_q.push_back({en ? oh : '0, dat});
    end
    tick();
    cmd_valid = 1'b0; cmd_ch = ~ch; cmd_m = ~m; cmd_d = ~d;
    for (int k = 0; k < n; k++) begin
      e = sb_q.pop_front();
      chk($sformatf("pattern_%0d", k), {progen, progdata}, e);
      chk("busy_during_prog", {busy, cmd_ready}, 2'b10);
      if (k < n - 1) tick();
    end
    sb_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_ch = '0; cmd_m = '0; cmd_d = '0;
    progdone = '0; locked = '0;
    repeat (3) tick();
    chk("reset_outs", {cmd_ready, progen, progdata, dcm_rst, busy, err}, 0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_reset", {cmd_ready, busy}, 2'b10);

    // Legal request: CH=1, M-1=34, D-1=7
    prog(2'd1, 8'd34, 8'd7, 23);
    tick();
    chk("progen_after_go", progen, 0);
    chk("err_cleared", err, 0);
    repeat (4) tick();
    progdone = 2'b10;
    repeat (20) tick();
    locked = 2'b10;
    tick();
    chk("busy_lock_sync1", {busy, cmd_ready}, 2'b10);
    tick();
    chk("busy_lock_sync2", {busy, cmd_ready}, 2'b10);
    tick();
    chk("idle_after_lock", {busy, cmd_ready, err, dcm_rst}, 6'b010000);
    progdone = '0;
    repeat (3) tick();

    // Illegal: M-1 = 0
    cmd_valid = 1'b1; cmd_ch = 2'd1; cmd_m = 8'd0; cmd_d = 8'd3;
    tick();
    cmd_valid = 1'b0;
    chk("illegal_m_err", err, 2'b10);
    for (int k = 0; k < 3; k++) begin
      chk("illegal_m_quiet", {progen, busy, cmd_ready}, 4'b0001);
      tick();
    end

    // Timeout: channel 0, boundary M-1=1, D-1=255, PROGDONE never comes
    prog(2'd0, 8'd1, 8'd255, 23);
    chk("timeout_err_clear", err, 2'b00);
    tick();
    for (int k = 1; k < TMO; k++) tick();
    chk("no_timeout_early", {err, dcm_rst}, 4'b0000);
    tick();
    chk("timeout_err", err, 2'b01);
    for (int k = 0; k < RSTC; k++) begin
      chk($sformatf("dcm_rst_pulse_%0d", k), {dcm_rst, busy, cmd_ready}, 4'b0110);
      tick();
    end
    chk("dcm_rst_end", {dcm_rst, busy, cmd_ready, err}, 6'b000101);

    // Reset during LOAD_M bit 4
    prog(2'd1, 8'hA5, 8'h3C, 16);
    rst_n = 1'b0;
    tick();
    chk("midrst_outs", {progen, busy, dcm_rst, cmd_ready, err}, 0);
    tick();
    chk("midrst_no_dcm_rst", dcm_rst, 0);
    rst_n = 1'b1;
    tick();
    chk("midrst_ready", {cmd_ready, busy, progen}, 4'b1000);

    // Illegal: channel 3 with two channels
    cmd_valid = 1'b1; cmd_ch = 2'd3; cmd_m = 8'd9; cmd_d = 8'd1;
    tick();
    cmd_valid = 1'b0;
    chk("illegal_ch_err", err, 2'b10);
    chk("illegal_ch_quiet", {progen, busy, cmd_ready}, 4'b0001);

`ifdef CMT_LOCK_MONITOR_EN
    locked = 2'b11;
    repeat (4) tick();
    locked = 2'b00;
    repeat (3) tick();
    for (int k = 0; k < RSTC; k++) begin
      chk("mon_rst0", {dcm_rst, busy}, 3'b011);
      tick();
    end
    chk("mon_gap", dcm_rst, 0);
    tick();
    for (int k = 0; k < RSTC; k++) begin
      chk("mon_rst1", {dcm_rst, busy}, 3'b101);
      tick();
    end
    chk("mon_done", {dcm_rst, busy}, 0);
`else
    locked = '0;
    for (int k = 0; k < 6; k++) begin
      chk("no_monitor", {dcm_rst, busy}, 0);
      tick();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
